ddr3_burst_writer: RTL and testbench
====================================

Name: ddr3_burst_writer

Overview:
- Avalon-MM burst write master for the DDRAM port, running in the clk_ddr3 domain.
- Fills a DDR3 region with a deterministic data pattern so that burst-read test logic can check the contents afterwards.
- Issues a configurable number of fixed-length bursts from a base address, with programmable idle gaps between bursts.
- Supports a graceful stop taken at the next burst boundary.

Parameters:
- ADDR_W, 29: DDRAM word-address width. One word is 64 bits.
- DATA_W, 64: DDRAM data width.
- WAIT_W, 10: width of the inter-burst gap counter.

Ports:
- clk  in  1: DDRAM clock (clk_ddr3). Also drives DDRAM_CLK at the top level.
- reset_n  in  1: asynchronous, active-low reset.
- start  in  1: single-cycle pulse. Latches all cfg_* inputs and begins a run.
- stop  in  1: single-cycle pulse. Requests a stop at the next burst boundary.
- cfg_base_addr  in  ADDR_W: first burst address.
- cfg_burst_len  in  8: beats per burst. A value of 0 is treated as 1.
- cfg_num_bursts  in  16: bursts per run. A value of 0 means free-run until stop.
- cfg_wait  in  WAIT_W: idle cycles before each burst.
- cfg_be  in  8: byte enables applied to every beat.
- cfg_seed  in  DATA_W: pattern seed.
- ddram_busy  in  1: Avalon waitrequest.
- ddram_burstcnt  out  8: burst length.
- ddram_addr  out  ADDR_W: burst start address.
- ddram_din  out  DATA_W: write data.
- ddram_be  out  8: byte enables.
- ddram_we  out  1: write request.
- busy  out  1: high while state is GAP or BURST.
- done  out  1: level, high while state is DONE.
- beats_written  out  24: count of accepted beats in the current run. Wraps at 2^24.

Behaviour:
- States: IDLE, GAP, BURST, DONE. Reset enters IDLE.
- Reset values: all outputs 0, except ddram_burstcnt = 1.
- IDLE or DONE, start=1:
  - Latch cfg_*.
  - Clear beats_written, burst index, wait counter and stop_pending.
  - Load pattern with the seed.
  - Go to GAP.
- stop in IDLE/DONE is ignored, including when it coincides with start. start outside IDLE/DONE is ignored.
- GAP:
  - wait_cnt increments each cycle.
  - When wait_cnt == latched wait: ddram_we←1, ddram_addr←current burst address, ddram_burstcnt←max(len,1); go to BURST.
  - Latency: start at edge N gives WE visible after edge N+1+wait.
  - stop_pending, or stop arriving in GAP: go to DONE with no write issued.
- BURST:
  - A beat is accepted on an edge with ddram_we & ~ddram_busy.
  - ddram_addr, ddram_burstcnt, ddram_be and ddram_we are held constant for the whole burst.
  - ddram_din is held while busy and advances only on acceptance.
  - Each acceptance: beats_written++, beat_cnt++, pattern advances.
  - On the last beat (beat_cnt == len-1):
    - ddram_we←0 on that edge.
    - Burst address += len (mod 2^ADDR_W).
    - burst_idx++.
    - Go to DONE if (num_bursts≠0 and burst_idx+1 == num_bursts) or stop_pending or stop is asserted that cycle. Otherwise go to GAP with wait_cnt←0.
  - stop during BURST sets stop_pending. It never truncates a burst.
- Pattern (default): beat k of the run carries cfg_seed + k (DATA_W-bit add, wraps).
- Address wrap past 2^ADDR_W-1 is silent modulo arithmetic.
- Asynchronous reset mid-burst drops ddram_we immediately. This protocol truncation is accepted only under reset.
- DONE holds all outputs, with ddram_we = 0, until the next start.

Optional Feature:
- Macro: DDR3W_LFSR_EN.
- When defined:
  - Data comes from a 64-bit Galois LFSR, taps x^64+x^63+x^61+x^60+1.
  - The LFSR is seeded from cfg_seed; a seed of 0 is replaced with 1.
  - It shifts once per accepted beat. Beat 0 equals the seed.
- When undefined: the incrementing pattern above is used, with no LFSR logic instantiated.

Decomposition:
- Package ddr3w_pkg holds:
  - the state enum (IDLE/GAP/BURST/DONE),
  - the LFSR tap constant 64'hD800_0000_0000_0000,
  - default widths.
- Sub-module ddr3w_pattern_gen (clk, reset_n, load, seed, advance, data) contains the incrementing/LFSR generator and owns the DDR3W_LFSR_EN switch.

Test Plan:
1. base=0x2400000, len=4, bursts=2, wait=0, busy=0, seed=0x10 -> 8 beats with din 0x10..0x17; addr 0x2400000 then 0x2400004; burstcnt=4; done=1; beats_written=8.
2. len=8, busy asserted on beats 2-4 for 3 cycles each -> addr/burstcnt/din stable during busy; no beat lost or duplicated; din strictly sequential.
3. bursts=0, wait=16, stop pulsed mid-burst 3 -> burst 3 completes with all 8 beats; no burst 4; done=1; beats_written=24 with len=8.
4. len=0, bursts=1 -> single beat, burstcnt=1.
5. base=0x1FFFFFFE, len=4, bursts=2 -> second burst address 0x00000002.
6. DDR3W_LFSR_EN, seed=0 -> beat0 din=1; beat1=0xD800000000000000; reset_n dropped mid-burst -> we=0 asynchronously, state IDLE.

Source files
------------

// File: rtl/ddr3w_pkg.sv
// ddr3w_pkg: shared types and constants for the DDR3 burst writer.
//   ddr3w_state_t   : writer FSM state encoding
//   DDR3W_LFSR_TAPS : Galois LFSR feedback mask, x^64+x^63+x^61+x^60+1
//   DDR3W_*_W       : default widths for the DDRAM port and the gap timer
package ddr3w_pkg;

   localparam int DDR3W_ADDR_W = 29;
   localparam int DDR3W_DATA_W = 64;
   localparam int DDR3W_WAIT_W = 10;

   localparam logic [63:0] DDR3W_LFSR_TAPS = 64'hD800_0000_0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GAP   = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } ddr3w_state_t;

endpackage

// File: rtl/ddr3w_pattern_gen.sv
// ddr3w_pattern_gen: write-data pattern source for the DDR3 burst writer.
// Build option: DDR3W_LFSR_EN selects a 64-bit Galois LFSR. It is seeded from
// seed, and a seed of 0 is forced to 1. Without the option the pattern is an
// incrementing count starting at seed.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load the generator from seed; takes priority over advance
//   seed         : pattern seed
//   advance      : step to the next beat's value
//   data         : current beat's value
module ddr3w_pattern_gen
   import ddr3w_pkg::*;
#(
   parameter int DATA_W = DDR3W_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] seed,
   input  logic              advance,
   output logic [DATA_W-1:0] data
);

`ifdef DDR3W_LFSR_EN
   localparam logic [DATA_W-1:0] TAPS = DATA_W'(DDR3W_LFSR_TAPS);
   localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

   logic [DATA_W-1:0] data_next;
   logic [DATA_W-1:0] seed_fix;

   // Right-shifting Galois form: the bit that drops out of the LSB feeds
   // back through the tap mask.
   assign data_next = (data >> 1) ^ (data[0] ? TAPS : '0);
   // An all-zero LFSR never leaves zero.
   assign seed_fix  = (seed == '0) ? ONE : seed;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= '0;
      end else if (load) begin
         data <= seed_fix;
      end else if (advance) begin
         data <= data_next;
      end
   end
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= '0;
      end else if (load) begin
         data <= seed;
      end else if (advance) begin
         data <= data + DATA_W'(1);
      end
   end
`endif

endmodule

// File: rtl/ddr3_burst_writer.sv
// ddr3_burst_writer: Avalon-MM burst write master that fills a DDR3 region
// with a deterministic pattern. It issues fixed-length bursts with idle gaps
// between them and stops gracefully at a burst boundary.
// Build option: DDR3W_LFSR_EN (in ddr3w_pattern_gen) switches the data
// pattern to an LFSR.
//   clk, reset_n   : clk_ddr3 domain clock, asynchronous active-low reset
//   start, stop    : run start (latches cfg_*) and boundary stop request
//   cfg_*          : base address, beats per burst, bursts per run (0 = free
//                    run), gap length, byte enables, pattern seed
//   ddram_*        : Avalon-MM write master (ddram_busy = waitrequest)
//   busy, done     : run in progress / run finished (level)
//   beats_written  : accepted beats in the current run
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_GAP   | counting idle cycles before the next burst
// ST_BURST | ddram_we high, transferring beats
// ST_DONE  | run finished, outputs held until the next start
module ddr3_burst_writer
   import ddr3w_pkg::*;
#(
   parameter int ADDR_W = DDR3W_ADDR_W,
   parameter int DATA_W = DDR3W_DATA_W,
   parameter int WAIT_W = DDR3W_WAIT_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [7:0]        cfg_burst_len,
   input  logic [15:0]       cfg_num_bursts,
   input  logic [WAIT_W-1:0] cfg_wait,
   input  logic [7:0]        cfg_be,
   input  logic [DATA_W-1:0] cfg_seed,
   input  logic              ddram_busy,
   output logic [7:0]        ddram_burstcnt,
   output logic [ADDR_W-1:0] ddram_addr,
   output logic [DATA_W-1:0] ddram_din,
   output logic [7:0]        ddram_be,
   output logic              ddram_we,
   output logic              busy,
   output logic              done,
   output logic [23:0]       beats_written
);

   ddr3w_state_t      state;
   logic [7:0]        len_q;
   logic [15:0]       num_q;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic [ADDR_W-1:0] burst_addr;
   logic [7:0]        beat_cnt;
   logic [15:0]       burst_idx;
   logic              stop_pending;

   logic idle_like;
   logic run_start;
   logic accept;
   logic last_beat;
   logic last_burst;

   assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
   assign run_start  = idle_like && start;
   assign accept     = (state == ST_BURST) && ddram_we && !ddram_busy;
   assign last_beat  = (beat_cnt == len_q - 8'd1);
   assign last_burst = (num_q != 16'd0) && (burst_idx + 16'd1 == num_q);

   assign busy = (state == ST_GAP) || (state == ST_BURST);
   assign done = (state == ST_DONE);

   ddr3w_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (run_start),
      .seed    (cfg_seed),
      .advance (accept),
      .data    (ddram_din)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         len_q          <= 8'd1;
         num_q          <= '0;
         wait_q         <= '0;
         wait_cnt       <= '0;
         burst_addr     <= '0;
         beat_cnt       <= '0;
         burst_idx      <= '0;
         stop_pending   <= 1'b0;
         beats_written  <= '0;
         ddram_we       <= 1'b0;
         ddram_addr     <= '0;
         ddram_burstcnt <= 8'd1;
         ddram_be       <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  len_q         <= (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;
                  num_q         <= cfg_num_bursts;
                  wait_q        <= cfg_wait;
                  wait_cnt      <= cfg_wait;
                  burst_addr    <= cfg_base_addr;
                  ddram_be      <= cfg_be;
                  beats_written <= '0;
                  beat_cnt      <= '0;
                  burst_idx     <= '0;
                  stop_pending  <= 1'b0;
                  state         <= ST_GAP;
               end
            end
            ST_GAP: begin
               // Gap timer counts down from the programmed wait; the burst
               // is issued on terminal count, giving wait idle cycles.
               if (stop || stop_pending) begin
                  state <= ST_DONE;
               end else if (wait_cnt == '0) begin
                  ddram_we       <= 1'b1;
                  ddram_addr     <= burst_addr;
                  ddram_burstcnt <= len_q;
                  beat_cnt       <= '0;
                  state          <= ST_BURST;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end
            ST_BURST: begin
               if (stop) begin
                  stop_pending <= 1'b1;
               end
               if (accept) begin
                  beats_written <= beats_written + 24'd1;
                  if (last_beat) begin
                     ddram_we   <= 1'b0;
                     burst_addr <= burst_addr + ADDR_W'(len_q);
                     burst_idx  <= burst_idx + 16'd1;
                     beat_cnt   <= '0;
                     if (last_burst || stop_pending || stop) begin
                        state <= ST_DONE;
                     end else begin
                        wait_cnt <= wait_q;
                        state    <= ST_GAP;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_burst_writer.sv
module tb_ddr3_burst_writer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [28:0] cfg_base_addr = '0;
   logic [7:0]  cfg_burst_len = '0;
   logic [15:0] cfg_num_bursts = '0;
   logic [9:0]  cfg_wait = '0;
   logic [7:0]  cfg_be = '0;
   logic [63:0] cfg_seed = '0;
   logic        ddram_busy = 1'b0;
   logic [7:0]  ddram_burstcnt;
   logic [28:0] ddram_addr;
   logic [63:0] ddram_din;
   logic [7:0]  ddram_be;
   logic        ddram_we;
   logic        busy;
   logic        done;
   logic [23:0] beats_written;

   int checks = 0;
   int passed = 0;
   int n_acc  = 0;

   ddr3_burst_writer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .stop           (stop),
      .cfg_base_addr  (cfg_base_addr),
      .cfg_burst_len  (cfg_burst_len),
      .cfg_num_bursts (cfg_num_bursts),
      .cfg_wait       (cfg_wait),
      .cfg_be         (cfg_be),
      .cfg_seed       (cfg_seed),
      .ddram_busy     (ddram_busy),
      .ddram_burstcnt (ddram_burstcnt),
      .ddram_addr     (ddram_addr),
      .ddram_din      (ddram_din),
      .ddram_be       (ddram_be),
      .ddram_we       (ddram_we),
      .busy           (busy),
      .done           (done),
      .beats_written  (beats_written)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Expected data of beat k of a run.
   function automatic logic [63:0] exp_data(input logic [63:0] seed, input int k);
      logic [63:0] v;
`ifdef DDR3W_LFSR_EN
      v = (seed == 64'd0) ? 64'd1 : seed;
      for (int i = 0; i < k; i++)
         v = (v >> 1) ^ (v[0] ? 64'hD800_0000_0000_0000 : 64'd0);
`else
      v = seed + 64'(k);
`endif
      return v;
   endfunction

   task automatic start_run(input logic [28:0] base, input logic [7:0] len,
                            input logic [15:0] nb, input logic [9:0] w,
                            input logic [7:0] be, input logic [63:0] seed,
                            input logic with_stop);
      cfg_base_addr  = base;
      cfg_burst_len  = len;
      cfg_num_bursts = nb;
      cfg_wait       = w;
      cfg_be         = be;
      cfg_seed       = seed;
      start          = 1'b1;
      stop           = with_stop;
      tick();
      start          = 1'b0;
      stop           = 1'b0;
      cfg_seed       = ~seed;
      cfg_base_addr  = ~base;
      cfg_burst_len  = 8'd3;
      cfg_be         = ~be;
   endtask

   // Drives ddram_busy/stop and checks every cycle that presents a write
   // until done or the cycle budget runs out. Beats busy_lo..busy_hi are
   // each held off for busy_n cycles; stop is pulsed once on beat stop_beat.
   task automatic run_collect(input int max_cycles, input int busy_lo, input int busy_hi,
                              input int busy_n, input int stop_beat,
                              input logic [63:0] seed, input logic [28:0] base,
                              input int len_eff, input logic [7:0] be);
      int cyc;
      int held;
      logic stop_sent;
      logic b;
      logic [28:0] ea;
      cyc = 0;
      held = 0;
      stop_sent = 1'b0;
      n_acc = 0;
      while (!done && cyc < max_cycles) begin
         b = 1'b0;
         if (ddram_we && n_acc >= busy_lo && n_acc <= busy_hi && held < busy_n) begin
            b = 1'b1;
            held++;
         end
         ddram_busy = b;
         stop = 1'b0;
         if (ddram_we && n_acc == stop_beat && !stop_sent) begin
            stop = 1'b1;
            stop_sent = 1'b1;
         end
         if (ddram_we) begin
            ea = base + 29'((n_acc / len_eff) * len_eff);
            chk($sformatf("din_beat%0d", n_acc), ddram_din, exp_data(seed, n_acc));
            chk($sformatf("addr_beat%0d", n_acc), 64'(ddram_addr), 64'(ea));
            chk($sformatf("burstcnt_beat%0d", n_acc), 64'(ddram_burstcnt), 64'(len_eff));
            chk($sformatf("be_beat%0d", n_acc), 64'(ddram_be), 64'(be));
            if (!b) begin
               n_acc++;
               held = 0;
            end
         end
         tick();
         cyc++;
      end
      stop = 1'b0;
      ddram_busy = 1'b0;
      chk("run_done", 64'(done), 64'd1);
   endtask

   initial begin
      // Reset state
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_we", 64'(ddram_we), 64'd0);
      chk("rst_burstcnt", 64'(ddram_burstcnt), 64'd1);
      chk("rst_addr", 64'(ddram_addr), 64'd0);
      chk("rst_din", ddram_din, 64'd0);
      chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
      reset_n = 1'b1;
      tick();

      // stop while idle is ignored
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      chk("idle_stop_busy_done", {62'd0, busy, done}, 64'd0);

      // 1: two bursts of 4, no gap, latency check
      start_run(29'h240_0000, 8'd4, 16'd2, 10'd0, 8'hA5, 64'h10, 1'b0);
      chk("t1_lat_we0", 64'(ddram_we), 64'd0);
      chk("t1_busy", 64'(busy), 64'd1);
      tick();
      chk("t1_lat_we1", 64'(ddram_we), 64'd1);
      run_collect(200, -1, -1, 0, -1, 64'h10, 29'h240_0000, 4, 8'hA5);
      chk("t1_beats", 64'(n_acc), 64'd8);
      chk("t1_beats_written", 64'(beats_written), 64'd8);
      chk("t1_last_addr", 64'(ddram_addr), 64'h240_0004);
      chk("t1_done_we", {62'd0, ddram_we, busy}, 64'd0);

      // 2: waitrequest held 3 cycles on beats 2..4, data wraps past 2^64
      start_run(29'h100, 8'd8, 16'd2, 10'd2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      run_collect(300, 2, 4, 3, -1, 64'hFFFF_FFFF_FFFF_FFFE, 29'h100, 8, 8'hFF);
      chk("t2_beats", 64'(n_acc), 64'd16);
      chk("t2_beats_written", 64'(beats_written), 64'd16);

      // 3: free run, wait 16, stop during third burst
      start_run(29'h4000, 8'd8, 16'd0, 10'd16, 8'h0F, 64'h1234, 1'b0);
      run_collect(400, -1, -1, 0, 19, 64'h1234, 29'h4000, 8, 8'h0F);
      chk("t3_beats", 64'(n_acc), 64'd24);
      chk("t3_beats_written", 64'(beats_written), 64'd24);
      chk("t3_last_addr", 64'(ddram_addr), 64'h4010);
      repeat (30) tick();
      chk("t3_still_done", {62'd0, done, ddram_we}, 64'd2);

      // 4: len 0 acts as 1; stop coincident with start is ignored
      start_run(29'h55, 8'd0, 16'd1, 10'd1, 8'h3C, 64'h99, 1'b1);
      chk("t4_started", 64'(busy), 64'd1);
      run_collect(100, -1, -1, 0, -1, 64'h99, 29'h55, 1, 8'h3C);
      chk("t4_beats", 64'(n_acc), 64'd1);
      chk("t4_beats_written", 64'(beats_written), 64'd1);
      chk("t4_burstcnt", 64'(ddram_burstcnt), 64'd1);

      // 5: address wraps past 2^29-1
      start_run(29'h1FFF_FFFE, 8'd4, 16'd2, 10'd3, 8'h81, 64'h0, 1'b0);
      run_collect(200, -1, -1, 0, -1, 64'h0, 29'h1FFF_FFFE, 4, 8'h81);
      chk("t5_wrap_addr", 64'(ddram_addr), 64'h2);
      chk("t5_beats_written", 64'(beats_written), 64'd8);

      // 6: seed 0, then asynchronous reset mid-burst
      start_run(29'h200, 8'd8, 16'd1, 10'd0, 8'hFF, 64'h0, 1'b0);
      tick();
      chk("t6_we", 64'(ddram_we), 64'd1);
      chk("t6_beat0", ddram_din, exp_data(64'h0, 0));
      tick();
      chk("t6_beat1", ddram_din, exp_data(64'h0, 1));
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_we", 64'(ddram_we), 64'd0);
      chk("t6_rst_state", {62'd0, busy, done}, 64'd0);
      chk("t6_rst_beats", 64'(beats_written), 64'd0);
      chk("t6_rst_burstcnt", 64'(ddram_burstcnt), 64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      tick();
      chk("t6_post_idle", {61'd0, busy, done, ddram_we}, 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
